// File: rtl/conv2_sequencer.sv
// Sequencer for one conv layer 2 pass: kicks the datapath, streams image/weight/bias
// words from the shared source memory, then captures feature-map words into the output buffer.
module conv2_sequencer #(
  parameter int IN_CHANNELS    = 2,
  parameter int OUT_CHANNELS   = 3,
  parameter int IN_IMG_SIZE    = 12,
  parameter int OUT_IMG_SIZE   = 10,
  parameter int KERNEL_SIZE    = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  src_rd_en,
  output logic [1:0]            src_sel,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0] src_rd_data,
  output logic                  conv_start,
  output logic                  conv_data_valid,
  output logic [DATA_WIDTH-1:0] conv_image,
  output logic [DATA_WIDTH-1:0] conv_weights,
  output logic [DATA_WIDTH-1:0] conv_biases,
  input  logic                  conv_result_valid,
  input  logic [DATA_WIDTH-1:0] conv_map,
  input  logic                  conv_finish,
  output logic                  map_wr_en,
  output logic [ADDR_WIDTH-1:0] map_wr_addr,
  output logic [DATA_WIDTH-1:0] map_wr_data
);

  localparam int IMG_TOTAL  = IN_CHANNELS * IN_IMG_SIZE * IN_IMG_SIZE;
  localparam int WGT_TOTAL  = IN_CHANNELS * OUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
  localparam int BIAS_TOTAL = OUT_CHANNELS;
  localparam int MAP_TOTAL  = OUT_CHANNELS * OUT_IMG_SIZE * OUT_IMG_SIZE;
  localparam int IMG_W  = $clog2(IMG_TOTAL + 1);
  localparam int WGT_W  = $clog2(WGT_TOTAL + 1);
  localparam int BIAS_W = $clog2(BIAS_TOTAL + 1);
  localparam int MAP_W  = $clog2(MAP_TOTAL + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE, S_KICK, S_LOAD_IMG, S_LOAD_WGT, S_LOAD_BIAS,
    S_FLUSH, S_WAIT_CONV, S_DONE, S_ERROR
  } state_t;

  state_t            state;
  logic [IMG_W-1:0]  img_cnt;
  logic [WGT_W-1:0]  wgt_cnt;
  logic [BIAS_W-1:0] bias_cnt;
  logic [MAP_W-1:0]  map_cnt;
  logic [TO_W-1:0]   timeout_cnt;
  logic              rv_q;
  logic              rd_q;
  logic [1:0]        sel_q;
  logic              rv_edge;
  logic              capture;
  logic [MAP_W-1:0]  map_cnt_next;

  // Read strobe must reflect this cycle's hold, so the source port is decoded from state.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    src_rd_en = 1'b0;
    src_sel   = 2'd0;
    src_addr  = '0;
    case (state)
      S_LOAD_IMG: begin
        src_rd_en = !hold;
        src_sel   = 2'd0;
        src_addr  = ADDR_WIDTH'(img_cnt);
      end
      S_LOAD_WGT: begin
        src_rd_en = !hold;
        src_sel   = 2'd1;
        src_addr  = ADDR_WIDTH'(wgt_cnt);
      end
      S_LOAD_BIAS: begin
        src_rd_en = !hold;
        src_sel   = 2'd2;
        src_addr  = ADDR_WIDTH'(bias_cnt);
      end
      default: ;
    endcase
  end

  // Read data arrives one cycle after the strobe; the captured select routes it.
  assign conv_data_valid = rd_q;
  assign conv_image      = (rd_q && sel_q == 2'd0) ? src_rd_data : '0;
  assign conv_weights    = (rd_q && sel_q == 2'd1) ? src_rd_data : '0;
  assign conv_biases     = (rd_q && sel_q == 2'd2) ? src_rd_data : '0;

  assign rv_edge      = conv_result_valid && !rv_q;
  assign capture      = (state == S_WAIT_CONV) && rv_edge && (map_cnt < MAP_W'(MAP_TOTAL));
  assign map_cnt_next = map_cnt + MAP_W'(capture);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      conv_start  <= 1'b0;
      map_wr_en   <= 1'b0;
      map_wr_addr <= '0;
      map_wr_data <= '0;
      img_cnt     <= '0;
      wgt_cnt     <= '0;
      bias_cnt    <= '0;
      map_cnt     <= '0;
      timeout_cnt <= '0;
      rv_q        <= 1'b0;
      rd_q        <= 1'b0;
      sel_q       <= 2'd0;
    end else begin
      rd_q       <= src_rd_en;
      sel_q      <= src_sel;
      rv_q       <= conv_result_valid;
      map_wr_en  <= 1'b0;
      done       <= 1'b0;
      conv_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state       <= S_KICK;
            busy        <= 1'b1;
            conv_start  <= 1'b1;
            error       <= 1'b0;
            img_cnt     <= '0;
            wgt_cnt     <= '0;
            bias_cnt    <= '0;
            map_cnt     <= '0;
            timeout_cnt <= '0;
          end
        end
        S_KICK: state <= S_LOAD_IMG;
        S_LOAD_IMG: if (!hold) begin
          img_cnt <= img_cnt + 1'b1;
          if (img_cnt == IMG_W'(IMG_TOTAL - 1)) state <= S_LOAD_WGT;
        end
        S_LOAD_WGT: if (!hold) begin
          wgt_cnt <= wgt_cnt + 1'b1;
          if (wgt_cnt == WGT_W'(WGT_TOTAL - 1)) state <= S_LOAD_BIAS;
        end
        S_LOAD_BIAS: if (!hold) begin
          bias_cnt <= bias_cnt + 1'b1;
          if (bias_cnt == BIAS_W'(BIAS_TOTAL - 1)) state <= S_FLUSH;
        end
        S_FLUSH: begin
          timeout_cnt <= '0;
          state       <= S_WAIT_CONV;
        end
        S_WAIT_CONV: begin
          if (capture) begin
            map_wr_en   <= 1'b1;
            map_wr_addr <= ADDR_WIDTH'(map_cnt);
            map_wr_data <= conv_map;
            map_cnt     <= map_cnt_next;
          end else if (rv_edge) begin
            error <= 1'b1;  // more results than the map holds
          end
          if (conv_finish) begin
            busy <= 1'b0;
            if (map_cnt_next == MAP_W'(MAP_TOTAL)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end else if (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state <= S_ERROR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2_sequencer.sv
// Self-checking bench for conv2_sequencer: a source memory and datapath stand-in driven from
// directed steps with random data/hold, compared against an expected stream built from the memory contents.
module tb_conv2_sequencer;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int IMG   = 288;
  localparam int WGT   = 54;
  localparam int BIAS  = 3;
  localparam int MAP   = 300;
  localparam int TO    = 8192;
  localparam int BEATS = IMG + WGT + BIAS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          busy, done, error;
  logic          src_rd_en;
  logic [1:0]    src_sel;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_rd_data = '0;
  logic          conv_start, conv_data_valid;
  logic [DW-1:0] conv_image, conv_weights, conv_biases;
  logic          conv_result_valid = 1'b0;
  logic [DW-1:0] conv_map = '0;
  logic          conv_finish = 1'b0;
  logic          map_wr_en;
  logic [AW-1:0] map_wr_addr;
  logic [DW-1:0] map_wr_data;

  conv2_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .busy(busy), .done(done), .error(error),
    .src_rd_en(src_rd_en), .src_sel(src_sel), .src_addr(src_addr), .src_rd_data(src_rd_data),
    .conv_start(conv_start), .conv_data_valid(conv_data_valid),
    .conv_image(conv_image), .conv_weights(conv_weights), .conv_biases(conv_biases),
    .conv_result_valid(conv_result_valid), .conv_map(conv_map), .conv_finish(conv_finish),
    .map_wr_en(map_wr_en), .map_wr_addr(map_wr_addr), .map_wr_data(map_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] img; logic [DW-1:0] wgt; logic [DW-1:0] bias; } beat_t;
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  logic [DW-1:0] img_mem [IMG];
  logic [DW-1:0] wgt_mem [WGT];
  logic [DW-1:0] bias_mem[BIAS];

  beat_t obs_beats[$];
  wr_t   obs_wr[$];
  wr_t   exp_wr[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hold_mode = 0;  // 0 none, 1 every third cycle, 2 random, 3 forced high
  int done_cnt, start_cnt, rd_cnt, start_cyc, first_beat_cyc, last_beat_cyc, err_cyc;
  bit err_seen;

  function automatic logic [DW-1:0] mem_word(input logic [1:0] sel, input logic [AW-1:0] addr);
    int a;
    a = int'(addr);
    case (sel)
      2'd0:    return (a < IMG)  ? img_mem[a]  : 16'hdead;
      2'd1:    return (a < WGT)  ? wgt_mem[a]  : 16'hdead;
      2'd2:    return (a < BIAS) ? bias_mem[a] : 16'hdead;
      default: return 16'hdead;
    endcase
  endfunction

  // Source memory: one-cycle read latency, garbage on cycles with no read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    src_rd_data <= src_rd_en ? mem_word(src_sel, src_addr) : DW'($urandom);
  end

  always @(negedge clk) begin
    if (conv_data_valid) begin
      obs_beats.push_back('{img: conv_image, wgt: conv_weights, bias: conv_biases});
      if (obs_beats.size() == 1) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
    end
    if (map_wr_en) obs_wr.push_back('{addr: map_wr_addr, data: map_wr_data});
    if (done) done_cnt++;
    if (conv_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (src_rd_en) rd_cnt++;
    if (error && !err_seen) begin
      err_seen = 1'b1;
      err_cyc  = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (hold_mode)
      1:       hold = (cyc % 3 == 0);
      2:       hold = ($urandom_range(0, 3) == 0);
      3:       hold = 1'b1;
      default: hold = 1'b0;
    endcase
  endtask

  task automatic fill_mem(input bit formula);
    for (int i = 0; i < IMG; i++)  img_mem[i]  = formula ? DW'(16'h1000 + i) : DW'($urandom);
    for (int i = 0; i < WGT; i++)  wgt_mem[i]  = formula ? DW'(16'h2000 + i) : DW'($urandom);
    for (int i = 0; i < BIAS; i++) bias_mem[i] = formula ? DW'(16'h3000 + i) : DW'($urandom);
  endtask

  task automatic begin_pass();
    obs_beats.delete();
    obs_wr.delete();
    exp_wr.delete();
    done_cnt = 0; start_cnt = 0; rd_cnt = 0; err_seen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_load(input string tag);
    int n = 0;
    while (obs_beats.size() < BEATS && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_load_in_time"}, 32'(n < 3000), 32'd1);
    tick();
  endtask

  task automatic emit_results(input int n);
    for (int i = 0; i < n; i++) begin
      conv_map = DW'($urandom);
      conv_result_valid = 1'b1;
      if (exp_wr.size() < MAP) exp_wr.push_back('{addr: AW'(exp_wr.size()), data: conv_map});
      tick();
      conv_result_valid = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_finish();
    conv_finish = 1'b1;
    tick();
    conv_finish = 1'b0;
    tick();
    tick();
  endtask

  // Expected stream: every image word, then every weight, then every bias, in address order.
  task automatic compare_beats(input string tag);
    int bad = 0;
    beat_t exp;
    check({tag, "_beat_count"}, 32'(obs_beats.size()), 32'(BEATS));
    for (int i = 0; i < BEATS; i++) begin
      if (i < IMG)            exp = '{img: img_mem[i], wgt: '0, bias: '0};
      else if (i < IMG + WGT) exp = '{img: '0, wgt: wgt_mem[i - IMG], bias: '0};
      else                    exp = '{img: '0, wgt: '0, bias: bias_mem[i - IMG - WGT]};
      if (i >= obs_beats.size() || obs_beats[i] !== exp) bad++;
    end
    check({tag, "_beat_value_errors"}, 32'(bad), 32'd0);
  endtask

  task automatic compare_writes(input string tag);
    int bad = 0;
    check({tag, "_write_count"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    foreach (exp_wr[i]) if (i >= obs_wr.size() || obs_wr[i] !== exp_wr[i]) bad++;
    check({tag, "_write_value_errors"}, 32'(bad), 32'd0);
  endtask

  task automatic full_pass(input string tag);
    begin_pass();
    wait_load(tag);
    emit_results(MAP);
    pulse_finish();
    compare_beats(tag);
    compare_writes(tag);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    bit found;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_flags", {busy, done, error, src_rd_en, conv_start, conv_data_valid, map_wr_en}, 32'd0);
    check("reset_buses", 32'(conv_image | conv_weights | conv_biases | map_wr_data), 32'd0);

    // Nominal pass with address-tagged source words
    fill_mem(1'b1);
    hold_mode = 0;
    begin_pass();
    check("nom_busy_rise", 32'(busy), 32'd1);
    check("nom_conv_start", 32'(conv_start), 32'd1);
    wait_load("nom");
    emit_results(MAP);
    pulse_finish();
    compare_beats("nom");
    compare_writes("nom");
    check("nom_first_latency", 32'(first_beat_cyc - start_cyc), 32'd2);
    check("nom_first_image", 32'(obs_beats.size() > 0 ? obs_beats[0].img : 16'h0), 32'h1000);
    check("nom_last_bias", 32'(obs_beats.size() == BEATS ? obs_beats[BEATS-1].bias : 16'h0), 32'h3002);
    check("nom_reads", 32'(rd_cnt), 32'(BEATS));
    check("nom_done_pulses", 32'(done_cnt), 32'd1);
    check("nom_error", 32'(error), 32'd0);
    check("nom_done_low_after", {busy, done}, 32'd0);

    // Hold on every third cycle
    hold_mode = 1;
    full_pass("hold3");
    check("hold3_reads", 32'(rd_cnt), 32'(BEATS));

    // Early finish after 299 results, then recovery
    fill_mem(1'b0);
    hold_mode = 2;
    begin_pass();
    wait_load("early");
    emit_results(MAP - 1);
    pulse_finish();
    compare_beats("early");
    check("early_done_pulses", 32'(done_cnt), 32'd0);
    check("early_error_busy", {error, busy}, 32'b10);
    tick();
    check("early_error_sticky", 32'(error), 32'd1);
    hold_mode = 0;
    full_pass("recover");

    // Timeout: datapath never finishes
    fill_mem(1'b0);
    begin_pass();
    wait_load("tmo");
    emit_results(MAP);
    n = 0;
    while (!err_seen && n < TO + 1000) begin
      tick();
      n++;
    end
    check("tmo_reached", 32'(err_seen), 32'd1);
    check("tmo_cycles", 32'(err_cyc - (last_beat_cyc + 1)), 32'(TO));
    tick();
    tick();
    check("tmo_error_busy", {error, busy, done}, 32'b100);
    check("tmo_done_pulses", 32'(done_cnt), 32'd0);

    // Reset while image address 150 is being read
    begin_pass();
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      tick();
      n++;
      found = src_rd_en && src_sel == 2'd0 && src_addr == AW'(150);
    end
    check("rst_mid_reached", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_flags", {busy, done, error, src_rd_en, conv_start, conv_data_valid, map_wr_en}, 32'd0);
    check("rst_mid_buses", 32'(conv_image | conv_weights | conv_biases), 32'd0);
    obs_beats.delete();
    rd_cnt = 0;
    tick();
    tick();
    check("rst_mid_idle_no_reads", 32'(rd_cnt + obs_beats.size()), 32'd0);
    full_pass("after_rst");

    // Hold high for 20 cycles after start, then a start pulse while busy
    fill_mem(1'b0);
    hold_mode = 3;
    begin_pass();
    for (int i = 0; i < 20; i++) tick();
    check("hold20_no_reads", 32'(rd_cnt), 32'd0);
    check("hold20_busy", 32'(busy), 32'd1);
    hold_mode = 0;
    hold = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_load("hold20");
    emit_results(MAP);
    pulse_finish();
    compare_beats("hold20");
    compare_writes("hold20");
    check("busy_start_ignored", 32'(start_cnt), 32'd1);
    check("hold20_done_pulses", 32'(done_cnt), 32'd1);
    check("hold20_error", 32'(error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv2_sequencer.md
Name: conv2_sequencer

Overview:
- Controller that sequences one pass of the second convolution layer. It starts the conv datapath, then streams the image, weight and bias words from a shared source memory in the order the datapath expects (image, then weights, then biases).
- It collects the produced feature-map words into an output buffer write port and reports done, or error on a count mismatch or timeout.
- It sits between the layer-level top controller (start/done) and conv_layer_2 plus its source and destination memories.

Parameters:
- IN_CHANNELS, 2, input channels
- OUT_CHANNELS, 3, output channels
- IN_IMG_SIZE, 12, input image side
- OUT_IMG_SIZE, 10, output image side
- KERNEL_SIZE, 3, kernel side
- DATA_WIDTH, 16, word width
- ADDR_WIDTH, 10, source/destination address width
- TIMEOUT_CYCLES, 8192, maximum cycles allowed in WAIT_CONV
- Derived: IMG_TOTAL = 288, WGT_TOTAL = 54, BIAS_TOTAL = 3, MAP_TOTAL = 300.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin one layer pass (sampled in IDLE/DONE/ERROR only)
- hold  in  1  source memory not granted; no read issued this cycle
- busy  out  1  high from the cycle after start is accepted until DONE/ERROR
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky fault flag, cleared by the next accepted start
- src_rd_en  out  1  source read strobe
- src_sel  out  2  0 = image, 1 = weights, 2 = biases
- src_addr  out  ADDR_WIDTH  word index within the selected region
- src_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after src_rd_en
- conv_start  out  1  start_conv2 to datapath
- conv_data_valid  out  1  data_valid to datapath
- conv_image  out  DATA_WIDTH  partial_image_in
- conv_weights  out  DATA_WIDTH  partial_weights_in
- conv_biases  out  DATA_WIDTH  partial_biases_in
- conv_result_valid  in  1  datapath result_valid
- conv_map  in  DATA_WIDTH  datapath map
- conv_finish  in  1  datapath finish_conv2
- map_wr_en  out  1  destination write strobe
- map_wr_addr  out  ADDR_WIDTH  destination address
- map_wr_data  out  DATA_WIDTH  destination data

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; all counters 0; error cleared. Reset asserted mid-pass aborts immediately. The next cycle shows all outputs 0, including no stray conv_data_valid for an in-flight read.
- States: IDLE, KICK, LOAD_IMG, LOAD_WGT, LOAD_BIAS, FLUSH, WAIT_CONV, DONE, ERROR.
- IDLE/DONE/ERROR, start=1: clear error and all counters, go to KICK. busy rises the next cycle.
- KICK (1 cycle): conv_start=1, no read. Next state is LOAD_IMG.
- LOAD_IMG: each cycle with hold=0 issues src_rd_en=1, src_sel=0, src_addr=img_cnt, and increments img_cnt. After issuing address 287, go to LOAD_WGT.
- hold=1: src_rd_en=0 and no counter change. The sequence resumes at the same address when hold falls.
- LOAD_WGT and LOAD_BIAS behave identically to LOAD_IMG with src_sel 1 (addresses 0..53) and src_sel 2 (addresses 0..2). After bias address 2 is issued, go to FLUSH.
- Return path: one cycle after each issued read, conv_data_valid=1. The captured src_sel of that read routes src_rd_data onto the matching conv_* bus; the other two buses are 0.
- conv_data_valid is 0 whenever no read was issued the previous cycle. This includes hold gaps and the state crossings.
- Exactly 345 conv_data_valid pulses are generated per pass.
- FLUSH (1 cycle): delivers the last bias, then go to WAIT_CONV and clear the timeout counter.
- WAIT_CONV capture:
  - A rising edge of conv_result_valid (registered previous value 0, current 1) while map_cnt < MAP_TOTAL writes one word. The sequencer registers map_wr_en=1, map_wr_addr=map_cnt, map_wr_data=conv_map for the next cycle, then increments map_cnt.
  - An edge with map_cnt == MAP_TOTAL produces no write and sets error.
- conv_finish=1 in WAIT_CONV:
  - If map_cnt == MAP_TOTAL (counting any capture in the same cycle), go to DONE with done=1 for one cycle.
  - Otherwise go to ERROR.
- conv_finish outside WAIT_CONV is ignored.
- Timeout: a counter increments every WAIT_CONV cycle. On reaching TIMEOUT_CYCLES-1 without conv_finish, go to ERROR.
- ERROR: error=1 (sticky), busy=0, no reads or writes. The state is held until start.
- start while busy is ignored; no restart occurs.
- All counters are unsigned, sized for their totals, and never wrap within a pass.

Test Plan:
- Nominal pass: source word = 0x1000+addr in image, 0x2000+addr in weights, 0x3000+addr in biases; hold=0; datapath model emits 300 result_valid edges then conv_finish -> 345 conv_data_valid pulses, the first carrying conv_image=0x1000 two cycles after conv_start, the last carrying conv_biases=0x3002; map addresses 0..299 written; done pulses once; error=0.
- Hold back-pressure: hold=1 on every third cycle during the load -> the same 345 values arrive in order, with no duplicates, no skips and no conv_data_valid during gap cycles.
- Early finish: conv_finish after 299 results -> no done; error=1; busy=0; a following start clears error and a complete pass succeeds.
- Timeout: datapath never finishes -> ERROR exactly TIMEOUT_CYCLES cycles after WAIT_CONV entry; error stays 1.
- Reset mid-load at image address 150 -> next cycle all outputs 0 and state IDLE; a new start reloads from image address 0.
- start pulsed while busy, and start with hold held high for 20 cycles -> no restart; loading begins only when hold falls.
